// File: rtl/parity_check_scheduler_pkg.sv
// Shared definitions for the parity-check scheduler: checker width, FSM states,
// and the even-parity error function used by the checker block.
package hc_parity_pkg;

    localparam int DATA_W     = 6;
    localparam int NUM_CH_DEF = 4;
    localparam int CH_W       = $clog2(NUM_CH_DEF);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Even parity: a word is bad when the XOR of all its bits is 1.
    function automatic logic parity_err(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/parity_check_scheduler_if.sv
// Request/result bus between the sensor front-ends, the scheduler and the
// alarm/display logic.
interface parity_check_scheduler_if import hc_parity_pkg::*; #(
    parameter int NUM_CH = 4
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        req_ready;
    logic                     res_valid;
    logic                     res_ready;
    logic [IDX_W-1:0]         res_ch;
    logic [DATA_W-1:0]        res_data;
    logic                     res_error;
    logic [NUM_CH-1:0]        warn;
    logic [NUM_CH-1:0]        warn_clr;

    modport master (
        output req_valid, req_data, res_ready, warn_clr,
        input  req_ready, res_valid, res_ch, res_data, res_error, warn
    );

    modport slave (
        input  req_valid, req_data, res_ready, warn_clr,
        output req_ready, res_valid, res_ch, res_data, res_error, warn
    );

endinterface

// File: rtl/parity_check_scheduler_arb.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx
);
    always_comb begin
        logic found;
        int   pos;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            pos = (int'(ptr) + int'(k)) % NUM_CH;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
            end
        end
    end
endmodule

// File: rtl/parity_checker.sv
// Existing 6-bit even-parity checker block.
module parity_checker import hc_parity_pkg::*; (
    input  logic [DATA_W-1:0] word,
    output logic              err
);
    assign err = parity_err(word);
endmodule

// File: rtl/parity_check_scheduler.sv
// Shares one parity checker between NUM_CH channels: round-robin issue, one
// registered result slot, per-channel consecutive-error counters and warnings.
module parity_check_scheduler import hc_parity_pkg::*; #(
    parameter int NUM_CH    = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    parity_check_scheduler_if.slave   bus
);
    localparam int         IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0] LIM   = 4'(ERR_LIMIT);

    state_t              state, state_n;
    logic [IDX_W-1:0]    ptr, gidx;
    logic [NUM_CH-1:0]   grant, req_ready;
    logic                issue_ok, accept, word_err;
    logic [DATA_W-1:0]   word;
    logic [IDX_W-1:0]    res_ch_q;
    logic [DATA_W-1:0]   res_data_q;
    logic                res_error_q;
    logic [3:0]          cnt   [NUM_CH];
    logic [3:0]          cnt_n [NUM_CH];
    logic [NUM_CH-1:0]   warn_q, warn_n;

    rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );

    assign word = bus.req_data[int'(gidx)*DATA_W +: DATA_W];

    parity_checker u_chk (
        .word (word),
        .err  (word_err)
    );

    // No grants while reset is held, so nothing is accepted during reset.
    assign issue_ok  = (state == ST_IDLE) | bus.res_ready;
    assign req_ready = reset ? '0 : (grant & {NUM_CH{issue_ok}});
    assign accept    = |req_ready;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_HOLD;
            ST_HOLD: if (bus.res_ready && !accept) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Clear is applied before the accepted word is counted.
    always_comb begin
        logic [3:0] base;
        base = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            base      = bus.warn_clr[i] ? 4'd0 : cnt[i];
            cnt_n[i]  = base;
            warn_n[i] = bus.warn_clr[i] ? 1'b0 : warn_q[i];
            if (accept && gidx == IDX_W'(i)) begin
                if (word_err) begin
                    cnt_n[i] = (base >= LIM) ? LIM : 4'(base + 4'd1);
                    if (cnt_n[i] == LIM) warn_n[i] = 1'b1;
                end else begin
                    cnt_n[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            res_error_q <= 1'b0;
            warn_q      <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            state  <= state_n;
            warn_q <= warn_n;
            for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= cnt_n[i];
            if (accept) begin
                ptr         <= (gidx == IDX_W'(NUM_CH - 1)) ? '0 : IDX_W'(gidx + 1'b1);
                res_ch_q    <= gidx;
                res_data_q  <= word;
                res_error_q <= word_err;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.res_valid = (state == ST_HOLD);
    assign bus.res_ch    = res_ch_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_error = res_error_q;
    assign bus.warn      = warn_q;

endmodule

// File: tb/tb_parity_check_scheduler.sv
// Directed bench for parity_check_scheduler with a cycle model and result scoreboard.
module tb_parity_check_scheduler;
    import hc_parity_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    parity_check_scheduler_if #(.NUM_CH(N)) bus ();

    parity_check_scheduler #(.NUM_CH(N), .ERR_LIMIT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] ch;
        logic [5:0] d;
        logic       e;
    } res_t;

    res_t         q[$];
    int           tests  = 0;
    int           errors = 0;
    logic         m_rv;
    int           m_ptr;
    int           m_cnt [N];
    logic [N-1:0] m_warn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_valid(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Check the DUT against the model at negedge, then advance the model to the next edge.
    task automatic tick();
        logic [N-1:0] exp_rdy;
        int           g;
        res_t         r;
        @(negedge clk);
        g       = first_valid(m_ptr, bus.req_valid);
        exp_rdy = '0;
        if (!reset && (!m_rv || bus.res_ready) && g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("res_valid", 32'(bus.res_valid), 32'(m_rv));
        chk("warn", 32'(bus.warn), 32'(m_warn));
        if (m_rv) begin
            if (q.size() == 0) begin
                tests++;
                errors++;
                $error("FAIL scoreboard: res_valid=1 observed, no result expected");
            end else begin
                chk("res_ch", 32'(bus.res_ch), 32'(q[0].ch));
                chk("res_data", 32'(bus.res_data), 32'(q[0].d));
                chk("res_error", 32'(bus.res_error), 32'(q[0].e));
            end
        end
        if (reset) begin
            m_rv   = 1'b0;
            m_ptr  = 0;
            m_cnt  = '{default: 0};
            m_warn = '0;
            q.delete();
        end else begin
            if (m_rv && bus.res_ready && q.size() > 0) void'(q.pop_front());
            for (int i = 0; i < N; i++) begin
                if (bus.warn_clr[i]) begin
                    m_cnt[i]  = 0;
                    m_warn[i] = 1'b0;
                end
            end
            if (exp_rdy != '0) begin
                r.ch = 2'(g);
                r.d  = bus.req_data[g*6 +: 6];
                r.e  = ^r.d;
                q.push_back(r);
                if (r.e) begin
                    if (m_cnt[g] < 3) m_cnt[g]++;
                    if (m_cnt[g] == 3) m_warn[g] = 1'b1;
                end else begin
                    m_cnt[g] = 0;
                end
                m_ptr = (g + 1) % N;
                m_rv  = 1'b1;
            end else if (m_rv && bus.res_ready) begin
                m_rv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] w2 [4];
        logic       e2 [4];
        logic [5:0] w3 [4];
        w2 = '{6'b000000, 6'b100001, 6'b000001, 6'b000011};
        e2 = '{1'b0, 1'b0, 1'b1, 1'b0};
        w3 = '{6'b000011, 6'b000101, 6'b000110, 6'b001001};

        reset         = 1'b1;
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.res_ready = 1'b1;
        bus.warn_clr  = '0;
        m_rv   = 1'b0;
        m_ptr  = 0;
        m_cnt  = '{default: 0};
        m_warn = '0;
        @(posedge clk);
        #1;

        // reset held with all channels requesting
        repeat (3) tick();
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_res_valid", 32'(bus.res_valid), 32'd0);
        chk("reset_warn", 32'(bus.warn), 32'd0);
        reset         = 1'b0;
        bus.req_valid = '0;
        tick();

        // parity patterns on ch0, back to back
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            bus.req_data[5:0] = w2[k];
            tick();
            chk("par_error", 32'(bus.res_error), 32'(e2[k]));
            chk("par_ch", 32'(bus.res_ch), 32'd0);
        end
        bus.req_valid = '0;
        tick();

        // pointer back to 0
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // round robin with all channels valid
        for (int c = 0; c < N; c++) bus.req_data[c*6 +: 6] = w3[c];
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_order", 32'(bus.res_ch), 32'(k % 4));
            chk("rr_valid", 32'(bus.res_valid), 32'd1);
        end
        bus.req_valid = '0;
        tick();

        // backpressure: result held, no grants, grant again on release
        bus.req_valid = 4'b0010;
        tick();
        bus.res_ready = 1'b0;
        bus.req_valid = '1;
        repeat (4) begin
            tick();
            chk("bp_data", 32'(bus.res_data), 32'(w3[1]));
            chk("bp_ch", 32'(bus.res_ch), 32'd1);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        tick();
        chk("bp_release_ch", 32'(bus.res_ch), 32'd2);
        bus.req_valid = '0;
        tick();

        // warning after three consecutive bad words on ch2
        bus.req_valid     = 4'b0100;
        bus.req_data[17:12] = 6'b000001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("warn2_build", 32'(bus.warn[2]), 32'(k == 2));
        end
        bus.req_data[17:12] = 6'b000000;
        tick();
        chk("warn2_sticky", 32'(bus.warn[2]), 32'd1);
        bus.req_valid = '0;
        bus.warn_clr  = 4'b0100;
        tick();
        bus.warn_clr  = '0;
        chk("warn2_clr", 32'(bus.warn[2]), 32'd0);

        // clear colliding with a bad word on ch1
        bus.req_valid     = 4'b0010;
        bus.req_data[11:6] = 6'b000001;
        repeat (3) tick();
        chk("warn1_set", 32'(bus.warn[1]), 32'd1);
        bus.warn_clr = 4'b0010;
        tick();
        bus.warn_clr = '0;
        chk("warn1_collide", 32'(bus.warn[1]), 32'd0);
        tick();
        chk("warn1_cnt2", 32'(bus.warn[1]), 32'd0);
        tick();
        chk("warn1_cnt3", 32'(bus.warn[1]), 32'd1);
        bus.req_valid = '0;
        tick();

        // reset while a result is held
        bus.req_valid = 4'b1000;
        bus.res_ready = 1'b0;
        tick();
        chk("hold_valid", 32'(bus.res_valid), 32'd1);
        bus.req_valid = '0;
        reset         = 1'b1;
        tick();
        chk("reset_hold_valid", 32'(bus.res_valid), 32'd0);
        reset         = 1'b0;
        bus.res_ready = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
